// File: rtl/pdp11_fetch_decode_pkg.sv
// Shared types, opcode constants and pre-decode helpers for the PDP-11 fetch/decode stage.
package pdp11_fetch_decode_pkg;

  typedef enum logic [3:0] {
    CL_DOP, CL_BR, CL_SOP, CL_JSR, CL_RTS, CL_JMP, CL_SWAB, CL_HALT, CL_NOP, CL_ILLEGAL
  } decode_class_t;

  typedef logic [2:0] mode_t;
  typedef logic [2:0] reg_t;

  localparam logic [15:0] OCT_HALT = 16'o000000;
  localparam logic [15:0] OCT_NOP  = 16'o000240;
  localparam logic [15:0] OCT_RTS  = 16'o000200;  // 00020R
  localparam logic [15:0] OCT_JMP  = 16'o000100;  // 0001DD
  localparam logic [15:0] OCT_SWAB = 16'o000300;  // 0003DD
  localparam logic [15:0] OCT_JSR  = 16'o004000;  // 004RDD

  // One extension word for indexed/deferred-indexed, or immediate/absolute via PC.
  function automatic logic [1:0] ext_words(mode_t mode, reg_t rn);
    return ((mode == 3'd6) || (mode == 3'd7) ||
            (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7))) ? 2'd1 : 2'd0;
  endfunction

  function automatic decode_class_t decode_class(logic [15:0] w);
    decode_class_t cl;
    cl = CL_ILLEGAL;
    if (w == OCT_HALT)                                        cl = CL_HALT;
    else if (w == OCT_NOP)                                    cl = CL_NOP;
    else if (w[15:3] == OCT_RTS[15:3])                        cl = CL_RTS;
    else if (w[15:6] == OCT_JMP[15:6])                        cl = CL_JMP;
    else if (w[15:6] == OCT_SWAB[15:6])                       cl = CL_SWAB;
    else if ((w[14:11] == 4'd0) && (w[15] || (w[10:8] != 3'd0))) cl = CL_BR;
    else if (w[15:9] == OCT_JSR[15:9])                        cl = CL_JSR;
    else if ((w[14:12] == 3'd0) && (w[11:6] >= 6'o50) && (w[11:6] <= 6'o63)) cl = CL_SOP;
    else if ((w[14:12] != 3'd0) && (w[14:12] != 3'd7))        cl = CL_DOP;
    return cl;
  endfunction

  function automatic logic [1:0] ext_count(logic [15:0] w, decode_class_t cl);
    logic [1:0] n;
    n = 2'd0;
    case (cl)
      CL_DOP:                         n = ext_words(w[11:9], w[8:6]) + ext_words(w[5:3], w[2:0]);
      CL_SOP, CL_JMP, CL_SWAB, CL_JSR: n = ext_words(w[5:3], w[2:0]);
      default:                        n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pdp11_prefetch_queue.sv
// Circular word FIFO with multi-entry pop and peek of the two words behind the head.
module pdp11_prefetch_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic [1:0]       pop_n,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head1,
  output logic [WIDTH-1:0] head2,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_q, wr_q, rd1, rd2;
  logic [CntW-1:0]  cnt_q;

  // Pointers and occupancy; flush wins over same-cycle push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(pop_n);
      cnt_q <= cnt_q + CntW'(push) - (pop ? CntW'(pop_n) : CntW'(0));
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end

  assign rd1   = rd_q + PtrW'(1);
  assign rd2   = rd_q + PtrW'(2);
  assign head  = mem_q[rd_q];
  assign head1 = mem_q[rd1];
  assign head2 = mem_q[rd2];
  assign count = cnt_q;

endmodule

// File: rtl/pdp11_fetch_decode.sv
// Byte-wise instruction prefetch, word queue and pre-decode feeding the execute stage.
module pdp11_fetch_decode
  import pdp11_fetch_decode_pkg::*;
#(
  parameter int unsigned         WORD_SIZE = 16,
  parameter int unsigned         MEM_WIDTH = 8,
  parameter int unsigned         ADDR_LEN  = 16,
  parameter int unsigned         QDEPTH    = 4,
  parameter logic [ADDR_LEN-1:0] RESET_PC  = 16'o001000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 redirect_valid,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic                 mem_req,
  output logic [ADDR_LEN-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [WORD_SIZE-1:0] ins_word,
  output logic [WORD_SIZE-1:0] ins_ext0,
  output logic [WORD_SIZE-1:0] ins_ext1,
  output logic [1:0]           ins_nwords,
  output logic [ADDR_LEN-1:0]  ins_pc,
  output decode_class_t        ins_class,
  output logic                 odd_addr_err
);

  localparam int unsigned BPW   = WORD_SIZE / MEM_WIDTH;
  localparam int unsigned LaneW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CntW  = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StAsm, StPush} fetch_state_e;

  fetch_state_e         state_q, state_d;
  logic [ADDR_LEN-1:0]  fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d, head_pc_q, head_pc_d;
  logic [LaneW-1:0]     lane_q, lane_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic                 discard_q, discard_d, halted_q, halted_d, odd_err_q, odd_err_d;

  logic [WORD_SIZE-1:0] head, head1, head2;
  logic [CntW-1:0]      count;
  decode_class_t        cls;
  logic [1:0]           ext_n, pop_n;
  logic                 bundle_ok, pop, push, can_fetch;

  pdp11_prefetch_queue #(
    .WIDTH (WORD_SIZE),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (word_q),
    .pop       (pop),
    .pop_n     (pop_n),
    .head      (head),
    .head1     (head1),
    .head2     (head2),
    .count     (count)
  );

  assign cls       = decode_class(head[15:0]);
  assign ext_n     = ext_count(head[15:0], cls);
  assign pop_n     = ext_n + 2'd1;
  assign bundle_ok = !halted_q && (int'(count) >= int'(pop_n));
  assign pop       = bundle_ok && ins_ready && !redirect_valid;
  assign can_fetch = !halted_d && !odd_err_q && (int'(count) < int'(QDEPTH));
  assign odd_addr_err = odd_err_q;

  // Bundle outputs are forced to an inert NOP whenever no complete bundle is queued.
  always_comb begin
    ins_valid  = bundle_ok;
    ins_word   = '0;
    ins_ext0   = '0;
    ins_ext1   = '0;
    ins_nwords = 2'd0;
    ins_pc     = '0;
    ins_class  = CL_NOP;
    if (bundle_ok) begin
      ins_word   = head;
      ins_nwords = ext_n;
      ins_pc     = head_pc_q;
      ins_class  = cls;
      if (ext_n != 2'd0) ins_ext0 = head1;
      if (ext_n == 2'd2) ins_ext1 = head2;
    end
  end

  // Halt, odd-address and head-PC tracking; redirect overrides any same-cycle pop.
  always_comb begin
    halted_d  = halted_q;
    odd_err_d = odd_err_q;
    head_pc_d = head_pc_q;
    if (redirect_valid) begin
      halted_d  = 1'b0;
      head_pc_d = redirect_pc;
      if (redirect_pc[0]) odd_err_d = 1'b1;
    end else if (pop) begin
      head_pc_d = head_pc_q + ADDR_LEN'({pop_n, 1'b0});
      if (cls == CL_HALT) halted_d = 1'b1;
    end
  end

  // Fetch FSM: one byte request at a time, word pushed the cycle after its last byte.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    lane_d     = lane_q;
    word_d     = word_q;
    discard_d  = discard_q;
    push       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    case (state_q)
      StIdle: begin
        if (!redirect_valid && can_fetch) begin
          req_addr_d = fetch_pc_q;
          lane_d     = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        mem_req  = 1'b1;
        mem_addr = req_addr_q;
        if (mem_ack) begin
          if (discard_q || redirect_valid) begin
            // Request was superseded: let it finish on the bus, throw the byte away.
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            word_d[MEM_WIDTH*int'(lane_q) +: MEM_WIDTH] = mem_rdata;
            state_d = (int'(lane_q) == int'(BPW) - 1) ? StPush : StAsm;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      StAsm: begin
        if (redirect_valid) begin
          state_d = StIdle;
        end else begin
          lane_d     = lane_q + LaneW'(1);
          req_addr_d = req_addr_q + ADDR_LEN'(1);
          state_d    = StReq;
        end
      end
      StPush: begin
        state_d = StIdle;
        if (!redirect_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_LEN'(2);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      head_pc_q  <= RESET_PC;
      lane_q     <= '0;
      word_q     <= '0;
      discard_q  <= 1'b0;
      halted_q   <= 1'b0;
      odd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_pc_q  <= head_pc_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
      odd_err_q  <= odd_err_d;
    end
  end

endmodule

// File: tb/tb_pdp11_fetch_decode.sv
// Directed self-checking bench for pdp11_fetch_decode with a byte memory model.
module tb_pdp11_fetch_decode;
  import pdp11_fetch_decode_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [15:0]   redirect_pc = '0;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          ins_valid;
  logic          ins_ready = 1'b0;
  logic [15:0]   ins_word, ins_ext0, ins_ext1, ins_pc;
  logic [1:0]    ins_nwords;
  decode_class_t ins_class;
  logic          odd_addr_err;

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay = 0;
  logic [7:0]  mem [65536];
  logic [15:0] fetch_log [$];

  always #5 clk = ~clk;

  pdp11_fetch_decode dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_word       (ins_word),
    .ins_ext0       (ins_ext0),
    .ins_ext1       (ins_ext1),
    .ins_nwords     (ins_nwords),
    .ins_pc         (ins_pc),
    .ins_class      (ins_class),
    .odd_addr_err   (odd_addr_err)
  );

  // Memory responder: acks a held request after ack_delay waiting cycles.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (reset_n && mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          fetch_log.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_nops();
    for (int a = 0; a < 65536; a++) mem[a] = a[0] ? 8'h00 : 8'hA0;
  endtask

  task automatic put_word(input logic [15:0] addr, input logic [15:0] w);
    mem[addr]              = w[7:0];
    mem[16'(addr + 16'd1)] = w[15:8];
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    repeat (2) tick();
    fetch_log.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (ins_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit seen;
    fill_nops();
    ack_delay = 0;
    reset_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_mem: req=%b addr=%o want 0 0", mem_req, mem_addr);
    end
    n_checks++;
    if (ins_valid !== 1'b0 || ins_class !== CL_NOP || ins_nwords !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_ins: valid=%b class=%0d n=%0d want 0 %0d 0", ins_valid, ins_class,
               ins_nwords, CL_NOP);
    end
    n_checks++;
    if (ins_word !== 16'd0 || ins_ext0 !== 16'd0 || ins_ext1 !== 16'd0 || ins_pc !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_data: word=%o ext0=%o ext1=%o pc=%o want all 0", ins_word, ins_ext0,
               ins_ext1, ins_pc);
    end
    n_checks++;
    if (odd_addr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_odd: got %b want 0", odd_addr_err);
    end
    // Reset during a pending request drops mem_req at once.
    ack_delay = 8;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = mem_req;
    end
    n_checks++;
    if (!seen || mem_addr !== 16'o001000) begin
      n_errors++;
      $display("FAIL reset_first_req: seen=%b addr=%o want 1 001000", seen, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midfetch: mem_req=%b want 0", mem_req);
    end
    tick();
    ack_delay = 0;
  endtask

  task automatic test_basic_fetch();
    bit ok;
    logic [15:0] exp_addr [4];
    exp_addr = '{16'o001000, 16'o001001, 16'o001002, 16'o001003};
    fill_nops();
    put_word(16'o001000, 16'o012700);
    put_word(16'o001002, 16'o000005);
    apply_reset();
    wait_valid(100, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_valid: no bundle within 100 cycles");
    end
    n_checks++;
    if (ins_word !== 16'o012700 || ins_class !== CL_DOP || ins_nwords !== 2'd1) begin
      n_errors++;
      $display("FAIL basic_decode: word=%o class=%0d n=%0d want 012700 %0d 1", ins_word,
               ins_class, ins_nwords, CL_DOP);
    end
    n_checks++;
    if (ins_ext0 !== 16'o000005 || ins_pc !== 16'o001000) begin
      n_errors++;
      $display("FAIL basic_ext: ext0=%o pc=%o want 000005 001000", ins_ext0, ins_pc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fetch_log.size() <= i || fetch_log[i] !== exp_addr[i]) begin
        n_errors++;
        $display("FAIL basic_addr[%0d]: got %o want %o", i,
                 (fetch_log.size() > i) ? fetch_log[i] : 16'hxxxx, exp_addr[i]);
      end
    end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    fill_nops();
    put_word(16'o001000, 16'o016162);
    put_word(16'o001002, 16'o000004);
    put_word(16'o001004, 16'o000006);
    apply_reset();
    wait_valid(200, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL stall_valid: no bundle within 200 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ins_valid !== 1'b1 || ins_word !== 16'o016162 || ins_ext0 !== 16'o4 ||
          ins_ext1 !== 16'o6 || ins_nwords !== 2'd2 || ins_pc !== 16'o001000 ||
          ins_class !== CL_DOP) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: v=%b w=%o e0=%o e1=%o n=%0d pc=%o cl=%0d want 1 016162 4 6 2 1000 %0d",
                 c, ins_valid, ins_word, ins_ext0, ins_ext1, ins_nwords, ins_pc, ins_class,
                 CL_DOP);
      end
      tick();
    end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    wait_valid(100, ok);
    n_checks++;
    if (!ok || ins_pc !== 16'o001006 || ins_class !== CL_NOP || ins_nwords !== 2'd0) begin
      n_errors++;
      $display("FAIL stall_next: ok=%b pc=%o class=%0d n=%0d want 1 001006 %0d 0", ok, ins_pc,
               ins_class, ins_nwords, CL_NOP);
    end
  endtask

  task automatic test_redirect_midfetch();
    bit ok;
    bit pending;
    int n0;
    fill_nops();
    put_word(16'o001000, 16'o000401);
    put_word(16'o002000, 16'o005000);
    ack_delay = 3;
    apply_reset();
    wait_valid(300, ok);
    n_checks++;
    if (!ok || ins_class !== CL_BR || ins_pc !== 16'o001000 || ins_nwords !== 2'd0) begin
      n_errors++;
      $display("FAIL br_decode: ok=%b class=%0d pc=%o n=%0d want 1 %0d 001000 0", ok, ins_class,
               ins_pc, ins_nwords, CL_BR);
    end
    pending = 1'b0;
    for (int i = 0; i < 30 && !pending; i++) begin
      if (mem_req && !mem_ack) pending = 1'b1;
      else tick();
    end
    n_checks++;
    if (!pending) begin
      n_errors++;
      $display("FAIL br_pending: no pending request within 30 cycles");
    end
    n0 = fetch_log.size();
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'o002000;
    tick();
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    n_checks++;
    if (ins_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL redirect_flush: ins_valid=%b want 0", ins_valid);
    end
    wait_valid(300, ok);
    n_checks++;
    if (!ok || ins_pc !== 16'o002000 || ins_word !== 16'o005000 || ins_class !== CL_SOP) begin
      n_errors++;
      $display("FAIL redirect_target: ok=%b pc=%o word=%o class=%0d want 1 002000 005000 %0d",
               ok, ins_pc, ins_word, ins_class, CL_SOP);
    end
    n_checks++;
    if (fetch_log.size() < n0 + 2 || fetch_log[n0 + 1] !== 16'o002000) begin
      n_errors++;
      $display("FAIL redirect_addr: log entries=%0d first new addr=%o want 002000",
               fetch_log.size(), (fetch_log.size() >= n0 + 2) ? fetch_log[n0 + 1] : 16'hxxxx);
    end
    ack_delay = 0;
  endtask

  task automatic test_odd_redirect();
    bit idle;
    bit req_seen;
    idle = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      if (!mem_req) idle = 1'b1;
      else tick();
    end
    n_checks++;
    if (!idle || odd_addr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL odd_pre: idle=%b odd_addr_err=%b want 1 0", idle, odd_addr_err);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'o002001;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (odd_addr_err !== 1'b1 || mem_req !== 1'b0 || ins_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL odd_err: err=%b req=%b valid=%b want 1 0 0", odd_addr_err, mem_req,
               ins_valid);
    end
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req || ins_valid || !odd_addr_err) req_seen = 1'b1;
    end
    n_checks++;
    if (req_seen) begin
      n_errors++;
      $display("FAIL odd_stuck: fetch or bundle resumed after odd redirect, want none");
    end
  endtask

  task automatic test_halt();
    bit ok;
    bit leaked;
    fill_nops();
    put_word(16'o001000, 16'o000000);
    put_word(16'o001002, 16'o005000);
    apply_reset();
    wait_valid(100, ok);
    n_checks++;
    if (!ok || ins_class !== CL_HALT || ins_pc !== 16'o001000 || ins_word !== 16'o0) begin
      n_errors++;
      $display("FAIL halt_decode: ok=%b class=%0d pc=%o word=%o want 1 %0d 001000 0", ok,
               ins_class, ins_pc, ins_word, CL_HALT);
    end
    ins_ready = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ins_valid) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin
      n_errors++;
      $display("FAIL halt_stall: ins_valid seen after HALT accepted, want 0");
    end
    ins_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'o001002;
    tick();
    redirect_valid = 1'b0;
    wait_valid(100, ok);
    n_checks++;
    if (!ok || ins_class !== CL_SOP || ins_pc !== 16'o001002 || ins_word !== 16'o005000) begin
      n_errors++;
      $display("FAIL halt_resume: ok=%b class=%0d pc=%o word=%o want 1 %0d 001002 005000", ok,
               ins_class, ins_pc, ins_word, CL_SOP);
    end
  endtask

  task automatic test_wrap_and_full();
    logic [15:0] exp_addr [8];
    exp_addr = '{16'o177776, 16'o177777, 16'o000000, 16'o000001,
                 16'o000002, 16'o000003, 16'o000004, 16'o000005};
    fill_nops();
    ack_delay = 0;
    reset_n   = 1'b0;
    ins_ready = 1'b0;
    repeat (2) tick();
    fetch_log.delete();
    reset_n        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'o177776;
    tick();
    redirect_valid = 1'b0;
    repeat (80) tick();
    n_checks++;
    if (fetch_log.size() != 8 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL full_count: bytes=%0d mem_req=%b want 8 0", fetch_log.size(), mem_req);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (fetch_log.size() <= i || fetch_log[i] !== exp_addr[i]) begin
        n_errors++;
        $display("FAIL wrap_addr[%0d]: got %o want %o", i,
                 (fetch_log.size() > i) ? fetch_log[i] : 16'hxxxx, exp_addr[i]);
      end
    end
    n_checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 16'o177776 || ins_class !== CL_NOP) begin
      n_errors++;
      $display("FAIL wrap_bundle: valid=%b pc=%o class=%0d want 1 177776 %0d", ins_valid, ins_pc,
               ins_class, CL_NOP);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_midfetch();
    test_odd_redirect();
    test_halt();
    test_wrap_and_full();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
